// File: rtl/osc_pkg.sv
// ---------------------------------------------------------------------------
// osc_pkg
// Shared definitions for the oscilloscope acquisition path.
//   strobe_state_t    : sequencing states of the sample strobe generator
//   MIN_SAMPLE_PERIOD : shortest legal spacing between sample strobes
//   DEFAULT_FRAME_LEN : samples per display frame (one per horizontal pixel)
//   effective_period  : clamps a requested period up to MIN_SAMPLE_PERIOD
// ---------------------------------------------------------------------------
package osc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        DONE
    } strobe_state_t;

    localparam int MIN_SAMPLE_PERIOD = 2;
    localparam int DEFAULT_FRAME_LEN = 640;

    // A period of 0 or 1 would make back-to-back strobes (or none at all),
    // so anything below the minimum is promoted to the minimum.
    function automatic logic [31:0] effective_period(input logic [31:0] requested);
        if (requested < 32'(MIN_SAMPLE_PERIOD)) begin
            return 32'(MIN_SAMPLE_PERIOD);
        end
        return requested;
    endfunction

endpackage

// File: rtl/period_counter.sv
// ---------------------------------------------------------------------------
// period_counter
// Free-running 32-bit cycle counter that wraps every latched period and
// flags the wrap cycle.
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high reset (count 0, period 2)
//   load_i   : latch max(period_i, 2) and restart counting from 0
//   clear_i  : restart counting from 0, keep the latched period
//   enable_i : advance the counter this cycle
//   period_i : requested clock cycles per wrap
//   wrap_o   : high in the cycle where the count reaches period-1 while enabled
// ---------------------------------------------------------------------------
module period_counter
    import osc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic [31:0] period_i,
    output logic        wrap_o
);

    logic [31:0] latchedPeriod_q;
    logic [31:0] latchedPeriod_d;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic        atEnd;

    // The latched period is never below 2, so period-1 cannot underflow and
    // an all-ones period still compares cleanly with no wider arithmetic.
    assign atEnd  = (count_q == (latchedPeriod_q - 32'd1));
    assign wrap_o = enable_i && atEnd;

    // Load takes priority over clear, and clear over counting, so a frame
    // restart or an abort always begins from a zero count.
    always_comb begin
        latchedPeriod_d = latchedPeriod_q;
        count_d         = count_q;
        if (load_i) begin
            latchedPeriod_d = effective_period(period_i);
            count_d         = 32'd0;
        end else if (clear_i) begin
            count_d = 32'd0;
        end else if (enable_i) begin
            count_d = atEnd ? 32'd0 : (count_q + 32'd1);
        end
    end

    // Counter and period registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            latchedPeriod_q <= 32'(MIN_SAMPLE_PERIOD);
            count_q         <= 32'd0;
        end else begin
            latchedPeriod_q <= latchedPeriod_d;
            count_q         <= count_d;
        end
    end

endmodule

// File: rtl/sample_strobe_gen.sv
// ---------------------------------------------------------------------------
// sample_strobe_gen
// Turns the clock-cycles-per-sample value from the timebase lookup into a
// one-cycle sample-enable strobe, sequencing one display frame of FRAME_LEN
// samples at a time and rearming while run stays high.
// Parameters:
//   FRAME_LEN : samples per frame (2..65535)
//   IDX_W     : width of sample_idx
// Ports:
//   clk           : system clock
//   reset         : synchronous, active-high reset
//   time_sampling : clock cycles between strobes (latched once per frame)
//   run           : level, 1 = acquire frames, 0 = stop/abort
//   single        : (SINGLE_SHOT_EN only) one frame per rising edge of run
//   sample_en     : one-cycle strobe, capture ADC sample now
//   sample_idx    : index of the strobed sample, valid while sample_en=1
//   frame_done    : one-cycle pulse after the last sample of a frame
//   busy          : high while a frame is being armed, run or completed
// Configuration macro: SINGLE_SHOT_EN adds the single port and edge-armed
// single-frame acquisition. Without it the block rearms continuously.
// ---------------------------------------------------------------------------
module sample_strobe_gen
    import osc_pkg::*;
#(
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      time_sampling,
    input  logic             run,
`ifdef SINGLE_SHOT_EN
    input  logic             single,
`endif
    output logic             sample_en,
    output logic [IDX_W-1:0] sample_idx,
    output logic             frame_done,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    strobe_state_t    state_q;
    strobe_state_t    state_d;
    logic [IDX_W-1:0] sampleIdx_q;
    logic [IDX_W-1:0] sampleIdx_d;
    logic             strobe;
    logic             startReq;
    logic             rearm;
    logic             counterLoad;
    logic             counterClear;
    logic             counterEnable;

`ifdef SINGLE_SHOT_EN
    logic runPrev_q;

    // Registered copy of run so single-shot mode can wait for a fresh
    // 0->1 transition before starting another frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            runPrev_q <= 1'b0;
        end else begin
            runPrev_q <= run;
        end
    end

    assign startReq = single ? (run && !runPrev_q) : run;
    assign rearm    = run && !single;
`else
    assign startReq = run;
    assign rearm    = run;
`endif

    // The counter restarts on ARM, holds at zero outside RUN, and is also
    // zeroed on the abort edge so an aborted frame leaves no stale count.
    assign counterLoad   = (state_q == ARM);
    assign counterEnable = (state_q == RUN);
    assign counterClear  = (state_q != RUN) || !run;

    period_counter u_period_counter (
        .clk      (clk),
        .reset    (reset),
        .load_i   (counterLoad),
        .clear_i  (counterClear),
        .enable_i (counterEnable),
        .period_i (time_sampling),
        .wrap_o   (strobe)
    );

    // State and sample index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sampleIdx_q <= '0;
        end else begin
            state_q     <= state_d;
            sampleIdx_q <= sampleIdx_d;
        end
    end

    // Next-state logic. Dropping run in ARM or RUN abandons the frame with
    // no done pulse; a strobe coming due in that same cycle still fires
    // because it depends only on the counter. The index returns to zero
    // whenever it is not counting through a live frame.
    always_comb begin
        state_d     = state_q;
        sampleIdx_d = '0;
        case (state_q)
            IDLE: begin
                if (startReq) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                state_d = run ? RUN : IDLE;
            end
            RUN: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (strobe) begin
                    if (sampleIdx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        sampleIdx_d = sampleIdx_q + IDX_W'(1);
                    end
                end else begin
                    sampleIdx_d = sampleIdx_q;
                end
            end
            DONE: begin
                state_d = rearm ? ARM : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only, so a reset clears all
    // of them on the same edge that returns the FSM to IDLE.
    always_comb begin
        sample_en  = strobe;
        sample_idx = sampleIdx_q;
        frame_done = (state_q == DONE);
        busy       = (state_q != IDLE);
    end

endmodule

// File: tb/tb_sample_strobe_gen.sv
// ---------------------------------------------------------------------------
// tb_sample_strobe_gen
// Scoreboard bench for sample_strobe_gen with an 8-sample frame. Each test
// pushes the cycle and index of every strobe (and the cycle of every
// frame_done) it expects, and the cycle stepper pops and compares them as
// the DUT produces them.
// ---------------------------------------------------------------------------
module tb_sample_strobe_gen;

    localparam int FL = 8;

    typedef struct {
        int cyc;
        int idx;
    } strobe_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [31:0] time_sampling = 32'd100;
`ifdef SINGLE_SHOT_EN
    logic        single = 1'b0;
`endif
    logic        sample_en;
    logic [2:0]  sample_idx;
    logic        frame_done;
    logic        busy;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    strobe_exp_t expQ[$];
    int          doneQ[$];

    sample_strobe_gen #(
        .FRAME_LEN (FL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .time_sampling (time_sampling),
        .run           (run),
`ifdef SINGLE_SHOT_EN
        .single        (single),
`endif
        .sample_en     (sample_en),
        .sample_idx    (sample_idx),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    // 10 time-unit clock; cyc numbers the cycle that begins at each rising edge.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Advance to the next falling edge and score any strobe or done pulse.
    task automatic tick();
        strobe_exp_t e;
        int          d;
        @(negedge clk);
        if (sample_en === 1'b1) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL strobe_unexpected: got strobe idx=%0d at cycle %0d, required none", sample_idx, cyc);
            end else begin
                e = expQ.pop_front();
                if (cyc !== e.cyc || sample_idx !== 3'(e.idx)) begin
                    bad++;
                    $display("[TB] FAIL strobe: got cycle=%0d idx=%0d, required cycle=%0d idx=%0d", cyc, sample_idx, e.cyc, e.idx);
                end
            end
        end
        if (frame_done === 1'b1) begin
            total++;
            if (doneQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL done_unexpected: got frame_done at cycle %0d, required none", cyc);
            end else begin
                d = doneQ.pop_front();
                if (cyc !== d) begin
                    bad++;
                    $display("[TB] FAIL frame_done: got cycle=%0d, required cycle=%0d", cyc, d);
                end
            end
        end
    endtask

    task automatic run_until(input int endCyc);
        while (cyc < endCyc) begin
            tick();
        end
    endtask

    // Expected strobes and done pulse for a full frame whose ARM is cycle t0.
    task automatic push_frame(input int t0, input int p);
        strobe_exp_t e;
        for (int k = 0; k < FL; k++) begin
            e.cyc = t0 + (k + 1) * p;
            e.idx = k;
            expQ.push_back(e);
        end
        doneQ.push_back(t0 + FL * p + 1);
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if (sample_en !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_sample_en: got %b, required 0", sample_en);
        end
        total++;
        if (sample_idx !== 3'd0) begin
            bad++;
            $display("[TB] FAIL reset_sample_idx: got %0d, required 0", sample_idx);
        end
        total++;
        if (frame_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_frame_done: got %b, required 0", frame_done);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_busy: got %b, required 0", busy);
        end
        reset = 1'b0;
        tick();
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_frame();
        int t0;
        time_sampling = 32'd100;
        run = 1'b1;
        t0 = cyc + 1;
        push_frame(t0, 100);
        run_until(t0);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL arm_busy: got %b, required 1", busy);
        end
        run_until(t0 + 801);
        total++;
        if (expQ.size() != 0 || doneQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL frame_pending: got strobes=%0d dones=%0d left, required 0 0", expQ.size(), doneQ.size());
        end
        run_until(t0 + 802);
        total++;
        if (busy !== 1'b1 || sample_idx !== 3'd0) begin
            bad++;
            $display("[TB] FAIL rearm: got busy=%b idx=%0d, required busy=1 idx=0", busy, sample_idx);
        end
        run = 1'b0;
        run_until(t0 + 803);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_in_arm: got busy=%b, required 0", busy);
        end
        run_until(t0 + 820);
    endtask

    task automatic test_min_period();
        int t0;
        for (int v = 0; v < 2; v++) begin
            time_sampling = 32'(v);
            run = 1'b1;
            t0 = cyc + 1;
            push_frame(t0, 2);
            run_until(t0 + 17);
            run = 1'b0;
            run_until(t0 + 18);
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL min_period_stop ts=%0d: got busy=%b, required 0", v, busy);
            end
            total++;
            if (expQ.size() != 0 || doneQ.size() != 0) begin
                bad++;
                $display("[TB] FAIL min_period_pending ts=%0d: got strobes=%0d dones=%0d left, required 0 0", v, expQ.size(), doneQ.size());
            end
        end
    endtask

    task automatic test_period_change();
        int t0;
        int t1;
        time_sampling = 32'd100;
        run = 1'b1;
        t0 = cyc + 1;
        push_frame(t0, 100);
        run_until(t0 + 350);
        time_sampling = 32'd400;
        t1 = t0 + 802;
        push_frame(t1, 400);
        run_until(t1 + 3201);
        run = 1'b0;
        run_until(t1 + 3202);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stop_in_done: got busy=%b, required 0", busy);
        end
        total++;
        if (expQ.size() != 0 || doneQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL change_pending: got strobes=%0d dones=%0d left, required 0 0", expQ.size(), doneQ.size());
        end
    endtask

    task automatic test_abort();
        int          t0;
        int          t1;
        strobe_exp_t e;
        time_sampling = 32'd10;
        run = 1'b1;
        t0 = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            e.cyc = t0 + (k + 1) * 10;
            e.idx = k;
            expQ.push_back(e);
        end
        run_until(t0 + 30);
        run = 1'b0;
        run_until(t0 + 31);
        total++;
        if (busy !== 1'b0 || sample_idx !== 3'd0 || frame_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort: got busy=%b idx=%0d done=%b, required 0 0 0", busy, sample_idx, frame_done);
        end
        run_until(t0 + 45);
        total++;
        if (expQ.size() != 0 || doneQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL abort_pending: got strobes=%0d dones=%0d left, required 0 0", expQ.size(), doneQ.size());
        end
        run = 1'b1;
        t1 = cyc + 1;
        push_frame(t1, 10);
        run_until(t1 + 81);
        run = 1'b0;
        run_until(t1 + 82);
        total++;
        if (busy !== 1'b0 || expQ.size() != 0 || doneQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL restart_after_abort: got busy=%b strobes=%0d dones=%0d left, required 0 0 0", busy, expQ.size(), doneQ.size());
        end
    endtask

    task automatic test_reset_mid_run();
        int          t0;
        int          t1;
        strobe_exp_t e;
        time_sampling = 32'd10;
        run = 1'b1;
        t0 = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            e.cyc = t0 + (k + 1) * 10;
            e.idx = k;
            expQ.push_back(e);
        end
        run_until(t0 + 20);
        reset = 1'b1;
        run_until(t0 + 21);
        total++;
        if (sample_en !== 1'b0 || sample_idx !== 3'd0 || frame_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_run: got en=%b idx=%0d done=%b busy=%b, required all 0", sample_en, sample_idx, frame_done, busy);
        end
        reset = 1'b0;
        run_until(t0 + 22);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL arm_after_reset: got busy=%b, required 1", busy);
        end
        t1 = t0 + 22;
        e.cyc = t1 + 10;
        e.idx = 0;
        expQ.push_back(e);
        run_until(t1 + 10);
        run = 1'b0;
        run_until(t1 + 12);
        total++;
        if (busy !== 1'b0 || expQ.size() != 0 || doneQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL reset_run_pending: got busy=%b strobes=%0d dones=%0d left, required 0 0 0", busy, expQ.size(), doneQ.size());
        end
    endtask

`ifdef SINGLE_SHOT_EN
    task automatic test_single_shot();
        int t0;
        int t1;
        single = 1'b1;
        time_sampling = 32'd3;
        run = 1'b1;
        t0 = cyc + 1;
        push_frame(t0, 3);
        run_until(t0 + 26);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_to_idle: got busy=%b, required 0", busy);
        end
        run_until(t0 + 40);
        total++;
        if (busy !== 1'b0 || expQ.size() != 0 || doneQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL single_hold: got busy=%b strobes=%0d dones=%0d left, required 0 0 0", busy, expQ.size(), doneQ.size());
        end
        run = 1'b0;
        tick();
        run = 1'b1;
        t1 = cyc + 1;
        push_frame(t1, 3);
        run_until(t1 + 40);
        total++;
        if (busy !== 1'b0 || expQ.size() != 0 || doneQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL single_retrigger: got busy=%b strobes=%0d dones=%0d left, required 0 0 0", busy, expQ.size(), doneQ.size());
        end
        run = 1'b0;
        single = 1'b0;
        tick();
    endtask
`endif

    // Test sequence.
    initial begin
        test_reset();
        test_frame();
        test_min_period();
        test_period_change();
        test_abort();
        test_reset_mid_run();
`ifdef SINGLE_SHOT_EN
        test_single_shot();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_strobe_gen.md
Name: sample_strobe_gen

Overview:
Sits directly downstream of the timebase lookup. Consumes the 32-bit clock-cycles-per-sample value and turns it into a one-cycle sample-enable strobe for the ADC capture / waveform buffer write path. It sequences one display frame of FRAME_LEN samples at a time. It rearms continuously while run is held high.

Parameters:
FRAME_LEN, 640, samples per frame (one per horizontal display pixel); legal range 2..65535
IDX_W, $clog2(FRAME_LEN), width of sample_idx

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
time_sampling  input  32  clock cycles between sample strobes, from the timebase lookup
run  input  1  level; 1 = acquire frames, 0 = stop/abort
sample_en  output  1  one-cycle strobe; capture ADC sample now
sample_idx  output  IDX_W  index of the sample being strobed; valid while sample_en=1
frame_done  output  1  one-cycle pulse after the last sample of a frame
busy  output  1  high in ARM, RUN and DONE states

Behaviour:
- One clock domain. Reset is synchronous and active-high; all logic is on the rising edge of clk.
- Reset values: sample_en=0, sample_idx=0, frame_done=0, busy=0, state=IDLE, period counter=0, latched period=2.
- Effective period is Pl = max(time_sampling, 2). Pl is latched only in ARM. Changes to time_sampling mid-frame are ignored until the next ARM.
- States:
  - IDLE: busy=0. If run=1, go to ARM next cycle.
  - ARM (1 cycle): latch Pl, clear the counter, clear the index. Go to RUN.
  - RUN: the counter increments each cycle. When counter==Pl-1:
    - sample_en=1 and the counter wraps to 0.
    - sample_idx increments after the strobe.
    - If the strobed index is FRAME_LEN-1, go to DONE.
  - DONE (1 cycle): frame_done=1. Next state is ARM if run=1, otherwise IDLE.
- Latency: if ARM occupies cycle t, the first strobe occurs at cycle t+Pl. Strobe k occurs at t+(k+1)*Pl. frame_done fires at t+FRAME_LEN*Pl+1.
- Inter-frame gap: DONE + ARM = 2 cycles, then Pl cycles to the first strobe of the next frame.
- run falling in ARM or RUN: abort. Go to IDLE the next cycle with no frame_done, and clear index and counter.
  - If run falls on the same cycle as a strobe, that strobe still occurs, but the frame is still aborted.
- run falling in DONE: frame_done still pulses, then go to IDLE.
- sample_en and frame_done are never high in the same cycle. sample_en is never high outside RUN.
- The counter is 32 bits and compares with ==. Pl=0xFFFFFFFF must work with no overflow.
- reset mid-frame: all outputs return to their reset values on the next edge, with no strobe or done.

Optional Feature:
SINGLE_SHOT_EN
- Defined: adds input port `single` (1 bit).
  - When single=1, DONE always goes to IDLE.
  - The block then waits in IDLE until run has been seen at 0 and then rises again (edge-armed, using a registered copy of run, reset value 0).
- Undefined: no `single` port. Behaviour is exactly as above, with continuous rearm.

Decomposition:
- Shared package osc_pkg holds:
  - typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} strobe_state_t
  - localparam MIN_SAMPLE_PERIOD = 2
  - localparam DEFAULT_FRAME_LEN = 640
- One sub-module is natural: period_counter. It takes a 32-bit load value and a clear input, and produces a wrap strobe. The FSM and index counter stay in the top module.

Test Plan:
- Reset, then run=1 with time_sampling=100 and FRAME_LEN=8 → ARM at t0, strobes at t0+100, 200, ... 800 with idx 0..7, frame_done at t0+801, next ARM at t0+802.
- time_sampling=0, then 1 → effective period 2; strobes every 2 cycles and never on consecutive cycles.
- time_sampling changed from 100 to 400 mid-frame → remaining strobes of that frame stay 100 apart; the next frame uses 400.
- run dropped after the 3rd strobe of an 8-sample frame → no frame_done, busy=0 next cycle, idx back to 0. Reasserting run gives a fresh frame starting at idx 0.
- reset pulsed mid-RUN on a strobe cycle → all outputs 0 on the next edge. run still 1 after reset → ARM the cycle after reset is released.
- SINGLE_SHOT_EN with single=1 and run held high → exactly one frame, then IDLE. A run 0→1 toggle starts exactly one more frame.
